// File: rtl/apb3_pkg.sv
// Shared APB3 definitions: default bus widths and master FSM state encoding.
// Reused by the APB router and any further APB masters.
package apb3_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb3_master_bridge.sv
// Valid/ready command stream to APB3 master bridge, with a wait-state timeout
// and a valid/ready response stream. One transfer is in flight at a time.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | cmd_ready=1, waiting for a command
// ST_SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
// ST_ACCESS | PSEL=1, PENABLE=1 until PREADY or the timeout fires
// ST_RESP   | rsp_valid=1, holding the response until rsp_ready
module apb3_master_bridge
    import apb3_pkg::*;
#(
    parameter int          ADDR_W         = ADDR_W_DEF,
    parameter int          DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              io_apb_PCLK,
    input  logic              io_apb_PRESET,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,

    output logic [ADDR_W-1:0] io_apb_PADDR,
    output logic              io_apb_PSEL,
    output logic              io_apb_PENABLE,
    input  logic              io_apb_PREADY,
    output logic              io_apb_PWRITE,
    output logic [DATA_W-1:0] io_apb_PWDATA,
    input  logic [DATA_W-1:0] io_apb_PRDATA,
    input  logic              io_apb_PSLVERROR
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    apb_state_e       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             timeout_hit;

    // Byte-lane bits of the address are dropped; transfers are word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cmd_addr[1:0];

    assign cmd_ready = (state == ST_IDLE);

    always_comb begin
        wait_cnt_inc = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
        timeout_hit  = TIMEOUT_EN && (wait_cnt_inc >= TIMEOUT_LIM);
    end

    always_ff @(posedge io_apb_PCLK or negedge io_apb_PRESET) begin
        if (!io_apb_PRESET) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            io_apb_PADDR   <= '0;
            io_apb_PSEL    <= 1'b0;
            io_apb_PENABLE <= 1'b0;
            io_apb_PWRITE  <= 1'b0;
            io_apb_PWDATA  <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_error      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        io_apb_PADDR  <= {cmd_addr[ADDR_W-1:2], 2'b00};
                        io_apb_PWRITE <= cmd_write;
                        io_apb_PWDATA <= cmd_write ? cmd_wdata : '0;
                        io_apb_PSEL   <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    io_apb_PENABLE <= 1'b1;
                    state          <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    // PREADY is checked first so it wins over a simultaneous timeout.
                    if (io_apb_PREADY) begin
                        rsp_rdata      <= io_apb_PWRITE ? '0 : io_apb_PRDATA;
                        rsp_error      <= io_apb_PSLVERROR;
                        io_apb_PSEL    <= 1'b0;
                        io_apb_PENABLE <= 1'b0;
                        rsp_valid      <= 1'b1;
                        state          <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (timeout_hit) begin
                            rsp_rdata      <= '0;
                            rsp_error      <= 1'b1;
                            io_apb_PSEL    <= 1'b0;
                            io_apb_PENABLE <= 1'b0;
                            rsp_valid      <= 1'b1;
                            state          <= ST_RESP;
                        end
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Self-checking bench for apb3_master_bridge: directed scenarios plus
// randomized transfers against a per-transfer expectation model.
module tb_apb3_master_bridge;

    localparam int TO = 8;
    localparam int STUCK = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic [15:0] paddr;
    logic        psel, penable, pready, pwrite, pslverror;
    logic [31:0] pwdata, prdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb3_master_bridge #(
        .ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .io_apb_PCLK(clk), .io_apb_PRESET(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .io_apb_PADDR(paddr), .io_apb_PSEL(psel), .io_apb_PENABLE(penable),
        .io_apb_PREADY(pready), .io_apb_PWRITE(pwrite), .io_apb_PWDATA(pwdata),
        .io_apb_PRDATA(prdata), .io_apb_PSLVERROR(pslverror)
    );

    // One complete transfer. waits = ACCESS cycles the slave holds PREADY low
    // before asserting it (STUCK = never); rsp_delay = cycles rsp_ready stays low.
    task automatic run_xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                            input int waits, input logic slverr, input logic [31:0] sdata,
                            input int rsp_delay);
        logic [15:0] e_addr;
        logic [31:0] e_wdata, e_rdata, h_rdata;
        logic        e_err, timed_out, done, h_err;
        int          e_acc, setup_n, acc_n, cyc;
        e_addr    = {addr[15:2], 2'b00};
        e_wdata   = wr ? wdata : 32'h0;
        timed_out = (TO != 0) && (waits >= TO);
        e_acc     = timed_out ? TO : waits + 1;
        e_rdata   = (wr || timed_out) ? 32'h0 : sdata;
        e_err     = timed_out || slverr;
        setup_n = 0; acc_n = 0; cyc = 1; done = 1'b0;

        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr; cmd_wdata = wdata;
        pready = 1'($urandom); prdata = $urandom; pslverror = 1'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = 16'($urandom); cmd_write = 1'($urandom); cmd_wdata = $urandom;

        while (!done && cyc <= 100) begin
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (psel && !penable) setup_n++;
                if (psel && penable) acc_n++;
                if (psel) begin
                    checks++;
                    if (paddr !== e_addr || pwrite !== wr || pwdata !== e_wdata) begin
                        failures++;
                        $display("FAIL apb_fields: got addr=%h wr=%b wdata=%h want addr=%h wr=%b wdata=%h",
                                 paddr, pwrite, pwdata, e_addr, wr, e_wdata);
                    end
                end
                if (psel && penable) begin
                    pready    = (acc_n > waits);
                    prdata    = pready ? sdata : $urandom;
                    pslverror = pready ? slverr : 1'($urandom);
                end else begin
                    pready = 1'($urandom); prdata = $urandom; pslverror = 1'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
        end

        checks++;
        if (!done) begin
            failures++; $display("FAIL rsp_timeout: no rsp_valid within 100 cycles");
            return;
        end
        checks++;
        if (cyc !== e_acc + 2 || setup_n !== 1 || acc_n !== e_acc) begin
            failures++;
            $display("FAIL latency: got rsp_cycle=%0d setup=%0d access=%0d want %0d/1/%0d",
                     cyc, setup_n, acc_n, e_acc + 2, e_acc);
        end
        checks++;
        if (rsp_rdata !== e_rdata || rsp_error !== e_err) begin
            failures++;
            $display("FAIL rsp_data: got rdata=%h err=%b want rdata=%h err=%b",
                     rsp_rdata, rsp_error, e_rdata, e_err);
        end
        h_rdata = rsp_rdata; h_err = rsp_error;

        for (int i = 0; i <= rsp_delay; i++) begin
            if (i > 0) @(negedge clk);
            pready = 1'($urandom); prdata = $urandom; pslverror = 1'($urandom);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== h_rdata || rsp_error !== h_err ||
                cmd_ready !== 1'b0 || psel !== 1'b0 || penable !== 1'b0 || paddr !== e_addr) begin
                failures++;
                $display("FAIL rsp_hold: got valid=%b rdata=%h err=%b rdy=%b psel=%b pen=%b addr=%h want 1/%h/%b/0/0/0/%h",
                         rsp_valid, rsp_rdata, rsp_error, cmd_ready, psel, penable, paddr,
                         h_rdata, h_err, e_addr);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || psel !== 1'b0) begin
            failures++;
            $display("FAIL rsp_handshake: got valid=%b cmd_ready=%b psel=%b want 0/1/0",
                     rsp_valid, cmd_ready, psel);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
        rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverror = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 ||
            paddr !== 16'h0 || pwdata !== 32'h0 || pwrite !== 1'b0 ||
            rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b psel=%b pen=%b rv=%b addr=%h wd=%h wr=%b rd=%h err=%b want 1,0...",
                     cmd_ready, psel, penable, rsp_valid, paddr, pwdata, pwrite, rsp_rdata, rsp_error);
        end
    endtask

    task automatic test_write_zero_wait();
        run_xfer(16'h1004, 1'b1, 32'hDEADBEEF, 0, 1'b0, 32'hCAFEF00D, 0);
    endtask

    task automatic test_read_wait_states();
        run_xfer(16'h0008, 1'b0, 32'h0, 3, 1'b0, 32'h12345678, 0);
    endtask

    task automatic test_timeout();
        run_xfer(16'h2010, 1'b0, 32'h0, STUCK, 1'b0, 32'hAAAA5555, 1);
        run_xfer(16'h2014, 1'b0, 32'h0, 0, 1'b0, 32'h0BADF00D, 0);
        // Ready on the last permitted ACCESS cycle still completes normally.
        run_xfer(16'h2018, 1'b0, 32'h0, TO - 1, 1'b0, 32'h55AA55AA, 0);
        run_xfer(16'h201C, 1'b1, 32'h11223344, TO, 1'b0, 32'h0, 0);
    endtask

    task automatic test_slverr();
        run_xfer(16'h1003, 1'b0, 32'h0, 0, 1'b1, 32'h87654321, 0);
        run_xfer(16'h3002, 1'b1, 32'h01020304, 2, 1'b1, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        run_xfer(16'h4000, 1'b0, 32'h0, 1, 1'b0, 32'hFEEDFACE, 10);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_xfer(16'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 10)),
                     1'($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid_access();
        int guard;
        guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 16'h5554; cmd_write = 1'b0; cmd_wdata = '0; pready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!(psel && penable) && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!(psel && penable)) begin
            failures++; $display("FAIL reach_access: got psel=%b pen=%b want 1/1", psel, penable);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got psel=%b pen=%b rv=%b want 0/0/0", psel, penable, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle: got rdy=%b rv=%b psel=%b want 1/0/0",
                         cmd_ready, rsp_valid, psel);
            end
        end
        run_xfer(16'h6008, 1'b0, 32'h0, 0, 1'b0, 32'h13572468, 0);
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_timeout();
        test_slverr();
        test_backpressure();
        test_random();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb3_master_bridge.md
Name: apb3_master_bridge

Overview:
Upstream stage that turns a simple valid/ready command stream, for example from a CPU data-port shim or a debug UART, into APB3 master transactions. It drives the 16-bit address / 32-bit data APB3 bus that the USART router decodes on PADDR[15:12]. It runs one transfer at a time, applies a wait-state timeout, and returns read data and error status on a valid/ready response stream.

Parameters:
ADDR_W, 16, APB address width; also the width of cmd_addr.
DATA_W, 32, data width of cmd_wdata, rsp_rdata, PWDATA and PRDATA.
TIMEOUT_CYCLES, 255, maximum ACCESS cycles with PREADY low before forced error termination; 0 disables the timeout.

Ports:
io_apb_PCLK  in  1  clock; all logic on its rising edge.
io_apb_PRESET  in  1  reset; asynchronous assert, active-low (0 = reset).
cmd_valid  in  1  command present.
cmd_ready  out  1  bridge accepts a command this cycle.
cmd_addr  in  ADDR_W  byte address.
cmd_write  in  1  1 = write, 0 = read.
cmd_wdata  in  DATA_W  write data.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_rdata  out  DATA_W  read data; 0 for writes and on timeout.
rsp_error  out  1  PSLVERROR was sampled, or the timeout fired.
io_apb_PADDR  out  ADDR_W  APB address, word aligned.
io_apb_PSEL  out  1  APB select.
io_apb_PENABLE  out  1  APB enable.
io_apb_PREADY  in  1  slave ready.
io_apb_PWRITE  out  1  APB direction.
io_apb_PWDATA  out  DATA_W  APB write data.
io_apb_PRDATA  in  DATA_W  APB read data.
io_apb_PSLVERROR  in  1  slave error.

Behaviour:
- Reset (io_apb_PRESET=0) takes effect immediately, without waiting for a clock edge.
  - State returns to IDLE and the timeout counter clears.
  - PSEL, PENABLE, PWRITE and rsp_valid go to 0; PADDR, PWDATA, rsp_rdata and rsp_error go to 0.
  - cmd_ready goes to 1 once reset is released.
  - No response is produced for a transfer aborted by reset.
- States are IDLE, SETUP, ACCESS and RESP, held in registered state.
- IDLE:
  - cmd_ready=1, combinationally equal to (state==IDLE).
  - On cmd_valid && cmd_ready, latch the command into the APB outputs:
    - PADDR = {cmd_addr[ADDR_W-1:2], 2'b00};
    - PWRITE = cmd_write;
    - PWDATA = cmd_wdata, or 0 for reads.
  - Then go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Go to ACCESS unconditionally after one cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - If PREADY=1:
    - latch rsp_rdata = PWRITE ? 0 : PRDATA and rsp_error = PSLVERROR;
    - drop PSEL and PENABLE on the next edge;
    - go to RESP.
  - If PREADY=0: increment the timeout counter. When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0):
    - latch rsp_rdata=0 and rsp_error=1;
    - drop PSEL and PENABLE;
    - go to RESP.
  - If PREADY=1 arrives in the same cycle the counter hits its limit, PREADY wins and the normal response is used.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_error stay stable until the handshake.
  - On rsp_ready=1, go to IDLE and clear the counter.
  - rsp_ready may be held low indefinitely; the bus stays idle meanwhile.
- PADDR, PWRITE and PWDATA hold their values from SETUP through the end of ACCESS, and stay stable in RESP and IDLE (no toggling).
- Latency:
  - With command handshake at edge T: SETUP in cycle T+1, ACCESS at T+2, rsp_valid at T+3 at the earliest (zero wait states).
  - Minimum 4 cycles per transfer when rsp_ready is held at 1; there is no overlap between transfers.
- Counter is a 16-bit saturating counter; TIMEOUT_CYCLES must be < 65536.
- cmd_addr[1:0] are ignored.
- cmd_* inputs are don't-care whenever cmd_ready=0.

Decomposition:
- Shared package apb3_pkg holds:
  - the ADDR_W/DATA_W defaults;
  - the state encoding localparams ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2, ST_RESP=2'd3.
  - The router and future APB masters reuse it.
- Single module; no sub-module is warranted.
- An optional SVA bind file checks:
  - PENABLE implies PSEL;
  - SETUP always precedes ACCESS;
  - address and data are stable while PSEL=1.

Test Plan:
- Write 0x1004, data 0xDEADBEEF, PREADY tied 1 → PADDR=0x1004, PWRITE=1 for 2 cycles (SETUP, ACCESS); rsp_valid at T+3 with rsp_error=0 and rsp_rdata=0.
- Read 0x0008, slave holds PREADY=0 for 3 ACCESS cycles then returns PRDATA=0x12345678 → PENABLE high for 4 cycles; rsp_rdata=0x12345678, rsp_error=0.
- Read with PREADY stuck at 0, TIMEOUT_CYCLES=8 → PSEL drops after 8 ACCESS cycles; rsp_error=1, rsp_rdata=0; the next command completes normally.
- Read 0x1003 with PSLVERROR=1 and PREADY=1 → PADDR=0x1000; rsp_error=1.
- rsp_ready held 0 for 10 cycles → rsp_valid and data stable, cmd_ready=0, PSEL=0 throughout; the handshake returns the bridge to IDLE the cycle after.
- Assert reset in the middle of ACCESS → PSEL, PENABLE and rsp_valid are 0 immediately, without a clock edge; after release, cmd_ready=1 and no stale response appears.
